// File: rtl/pipe_hazard_ctrl.sv
// Hazard detection, operand-forwarding selection and memory-wait freeze control
// for an in-order pipeline with STAGES producer entries behind ID (0 = EXE).
module pipe_hazard_ctrl #(
    parameter int REG_W    = 4,
    parameter int STAGES   = 3,
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 15,
    localparam int SEL_W   = $clog2(STAGES)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      forwarding_en,
    input  logic                      id_valid,
    input  logic [REG_W-1:0]          id_rn,
    input  logic [REG_W-1:0]          id_rm,
    input  logic                      id_two_src,
    input  logic [STAGES-1:0]         stg_wb_en,
    input  logic [STAGES-1:0]         stg_mem_read,
    input  logic [STAGES*REG_W-1:0]   stg_dest,
    input  logic                      branch_taken,
    input  logic                      mem_req,
    input  logic                      mem_ready,
    input  logic                      cnt_clr,
    output logic                      hazard_detected,
    output logic                      flush,
    output logic                      freeze,
    output logic [SEL_W-1:0]          fwd_sel_rn,
    output logic [SEL_W-1:0]          fwd_sel_rm,
    output logic                      mem_timeout,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic [CNT_W-1:0]          fwd_cnt
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic [STAGES-1:0] match_rn;
    logic [STAGES-1:0] match_rm;
    logic [SEL_W-1:0]  fwd_sel_rn_next;
    logic [SEL_W-1:0]  fwd_sel_rm_next;
    logic              fwd_load_nz;

    logic [SEL_W-1:0]  fwd_sel_rn_reg;
    logic [SEL_W-1:0]  fwd_sel_rm_reg;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic              mem_timeout_reg;
    logic [CNT_W-1:0]  stall_cnt_reg;
    logic [CNT_W-1:0]  fwd_cnt_reg;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_match
            assign match_rn[gi] = id_valid & stg_wb_en[gi]
                                & (stg_dest[gi*REG_W +: REG_W] == id_rn);
            assign match_rm[gi] = id_valid & id_two_src & stg_wb_en[gi]
                                & (stg_dest[gi*REG_W +: REG_W] == id_rm);
        end
    endgenerate

    assign flush  = branch_taken;
    assign freeze = mem_req & ~mem_ready;

    // With forwarding only a load still in EXE cannot be bypassed in time.
    always_comb begin
        hazard_detected = 1'b0;
        if (!branch_taken) begin
            if (forwarding_en)
                hazard_detected = (match_rn[0] | match_rm[0]) & stg_mem_read[0];
            else
                hazard_detected = |{match_rn, match_rm};
        end
    end

    // Scan oldest-to-youngest so the youngest producer wins; WB is left to the RF.
    always_comb begin
        fwd_sel_rn_next = '0;
        fwd_sel_rm_next = '0;
        if (forwarding_en && !hazard_detected && !branch_taken && id_valid) begin
            for (int k = STAGES - 2; k >= 0; k--) begin
                if (match_rn[k]) fwd_sel_rn_next = SEL_W'(k + 1);
                if (match_rm[k]) fwd_sel_rm_next = SEL_W'(k + 1);
            end
        end
    end

    assign fwd_load_nz = (fwd_sel_rn_next != '0) || (fwd_sel_rm_next != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_sel_rn_reg  <= '0;
            fwd_sel_rm_reg  <= '0;
            wait_cnt_reg    <= '0;
            mem_timeout_reg <= 1'b0;
            stall_cnt_reg   <= '0;
            fwd_cnt_reg     <= '0;
        end else begin
            if (!freeze) begin
                fwd_sel_rn_reg <= fwd_sel_rn_next;
                fwd_sel_rm_reg <= fwd_sel_rm_next;
            end

            if (!freeze)
                wait_cnt_reg <= '0;
            else if (wait_cnt_reg != WAIT_W'(MAX_WAIT))
                wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);

            if (freeze && (wait_cnt_reg == WAIT_W'(MAX_WAIT - 1)))
                mem_timeout_reg <= 1'b1;

            if (cnt_clr)
                stall_cnt_reg <= '0;
            else if (hazard_detected && !freeze && (stall_cnt_reg != '1))
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);

            if (cnt_clr)
                fwd_cnt_reg <= '0;
            else if (fwd_load_nz && !freeze && (fwd_cnt_reg != '1))
                fwd_cnt_reg <= fwd_cnt_reg + CNT_W'(1);
        end
    end

    assign fwd_sel_rn  = fwd_sel_rn_reg;
    assign fwd_sel_rm  = fwd_sel_rm_reg;
    assign mem_timeout = mem_timeout_reg;
    assign stall_cnt   = stall_cnt_reg;
    assign fwd_cnt     = fwd_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: expected register state is queued as each
// step is driven and popped for comparison after the clock edge that produces it.
module tb_pipe_hazard_ctrl;

    localparam int REG_W    = 4;
    localparam int STAGES   = 3;
    localparam int CNT_W    = 4;
    localparam int MAX_WAIT = 15;
    localparam int SEL_W    = 2;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    forwarding_en = 1'b0;
    logic                    id_valid = 1'b0;
    logic [REG_W-1:0]        id_rn = '0;
    logic [REG_W-1:0]        id_rm = '0;
    logic                    id_two_src = 1'b0;
    logic [STAGES-1:0]       stg_wb_en = '0;
    logic [STAGES-1:0]       stg_mem_read = '0;
    logic [STAGES*REG_W-1:0] stg_dest = '0;
    logic                    branch_taken = 1'b0;
    logic                    mem_req = 1'b0;
    logic                    mem_ready = 1'b0;
    logic                    cnt_clr = 1'b0;
    logic                    hazard_detected;
    logic                    flush;
    logic                    freeze;
    logic [SEL_W-1:0]        fwd_sel_rn;
    logic [SEL_W-1:0]        fwd_sel_rm;
    logic                    mem_timeout;
    logic [CNT_W-1:0]        stall_cnt;
    logic [CNT_W-1:0]        fwd_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .REG_W(REG_W), .STAGES(STAGES), .CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk), .rst(rst), .forwarding_en(forwarding_en), .id_valid(id_valid),
        .id_rn(id_rn), .id_rm(id_rm), .id_two_src(id_two_src),
        .stg_wb_en(stg_wb_en), .stg_mem_read(stg_mem_read), .stg_dest(stg_dest),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .cnt_clr(cnt_clr), .hazard_detected(hazard_detected), .flush(flush),
        .freeze(freeze), .fwd_sel_rn(fwd_sel_rn), .fwd_sel_rm(fwd_sel_rm),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
    );

    typedef struct {
        string            tag;
        logic [SEL_W-1:0] rn;
        logic [SEL_W-1:0] rm;
        logic [CNT_W-1:0] stall;
        logic [CNT_W-1:0] fwd;
        logic             tmo;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [SEL_W-1:0] exp_rn    = '0;
    logic [SEL_W-1:0] exp_rm    = '0;
    logic [CNT_W-1:0] exp_stall = '0;
    logic [CNT_W-1:0] exp_fwd   = '0;
    logic             exp_tmo   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic push_exp(input string tag);
        exp_t e;
        e.tag = tag; e.rn = exp_rn; e.rm = exp_rm;
        e.stall = exp_stall; e.fwd = exp_fwd; e.tmo = exp_tmo;
        sb.push_back(e);
    endtask

    task automatic check_regs();
        exp_t e;
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            $display("[%0t] %s sel_rn=%0d sel_rm=%0d stall=%0d fwd=%0d tmo=%0b", $time,
                     e.tag, fwd_sel_rn, fwd_sel_rm, stall_cnt, fwd_cnt, mem_timeout);
            chk({e.tag, "/sel_rn"}, 32'(fwd_sel_rn), 32'(e.rn));
            chk({e.tag, "/sel_rm"}, 32'(fwd_sel_rm), 32'(e.rm));
            chk({e.tag, "/stall"},  32'(stall_cnt),  32'(e.stall));
            chk({e.tag, "/fwd"},    32'(fwd_cnt),    32'(e.fwd));
            chk({e.tag, "/tmo"},    32'(mem_timeout), 32'(e.tmo));
        end
    endtask

    task automatic clock_step(input string tag);
        push_exp(tag);
        @(posedge clk);
        #1;
        check_regs();
    endtask

    task automatic comb(input string tag, input logic haz, input logic fl, input logic frz);
        #1;
        chk({tag, "/hazard"}, 32'(hazard_detected), 32'(haz));
        chk({tag, "/flush"},  32'(flush),           32'(fl));
        chk({tag, "/freeze"}, 32'(freeze),          32'(frz));
    endtask

    task automatic set_stage(input int k, input logic wb, input logic mr, input logic [REG_W-1:0] d);
        stg_wb_en[k]             = wb;
        stg_mem_read[k]          = mr;
        stg_dest[k*REG_W +: REG_W] = d;
    endtask

    task automatic drive(input logic fen, input logic v, input logic [REG_W-1:0] rn,
                         input logic [REG_W-1:0] rm, input logic two);
        forwarding_en = fen; id_valid = v; id_rn = rn; id_rm = rm; id_two_src = two;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state and combinational pass-through during reset
        branch_taken = 1'b1;
        #2;
        comb("rst_comb", 1'b0, 1'b1, 1'b0);
        push_exp("rst_state");
        check_regs();

        @(negedge clk);
        rst = 1'b1;
        branch_taken = 1'b0;

        // Forward from EXE entry (select 1)
        set_stage(0, 1'b1, 1'b0, 4'd3);
        drive(1'b1, 1'b1, 4'd3, 4'd0, 1'b0);
        comb("fwd_exe", 1'b0, 1'b0, 1'b0);
        exp_rn = 2'd1; exp_fwd = 4'd1;
        clock_step("fwd_exe");

        // Load-use on Rm
        @(negedge clk);
        set_stage(0, 1'b1, 1'b1, 4'd5);
        drive(1'b1, 1'b1, 4'd1, 4'd5, 1'b1);
        comb("load_use", 1'b1, 1'b0, 1'b0);
        exp_rn = 2'd0; exp_rm = 2'd0; exp_stall = 4'd1;
        clock_step("load_use");

        // Same register now one stage older: forwarded from MEM
        @(negedge clk);
        set_stage(0, 1'b0, 1'b0, 4'd0);
        set_stage(1, 1'b1, 1'b0, 4'd5);
        comb("fwd_mem_rm", 1'b0, 1'b0, 1'b0);
        exp_rm = 2'd2; exp_fwd = 4'd2;
        clock_step("fwd_mem_rm");

        // Forwarding disabled: any match stalls
        @(negedge clk);
        set_stage(1, 1'b1, 1'b0, 4'd7);
        drive(1'b0, 1'b1, 4'd7, 4'd0, 1'b1);
        comb("nofwd_rn", 1'b1, 1'b0, 1'b0);
        exp_rm = 2'd0; exp_stall = 4'd2;
        clock_step("nofwd_rn");

        @(negedge clk);
        drive(1'b0, 1'b1, 4'd2, 4'd7, 1'b0);
        comb("nofwd_rm_unused", 1'b0, 1'b0, 1'b0);
        clock_step("nofwd_rm_unused");

        @(negedge clk);
        drive(1'b0, 1'b0, 4'd7, 4'd7, 1'b1);
        comb("nofwd_invalid", 1'b0, 1'b0, 1'b0);
        clock_step("nofwd_invalid");

        // WB-only match is never forwarded
        @(negedge clk);
        set_stage(1, 1'b0, 1'b0, 4'd0);
        set_stage(2, 1'b1, 1'b0, 4'd7);
        drive(1'b1, 1'b1, 4'd7, 4'd0, 1'b0);
        comb("wb_only", 1'b0, 1'b0, 1'b0);
        clock_step("wb_only");

        // MEM and WB both match: youngest (MEM) wins
        @(negedge clk);
        set_stage(1, 1'b1, 1'b0, 4'd7);
        comb("fwd_mem_rn", 1'b0, 1'b0, 1'b0);
        exp_rn = 2'd2; exp_fwd = 4'd3;
        clock_step("fwd_mem_rn");

        // Freeze for 16 edges: selects hold, timeout after the 15th edge
        @(negedge clk);
        drive(1'b1, 1'b0, 4'd7, 4'd0, 1'b0);
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i != 0) @(negedge clk);
            comb("freeze", 1'b0, 1'b0, 1'b1);
            exp_tmo = (i >= 14);
            clock_step($sformatf("freeze%0d", i + 1));
        end

        @(negedge clk);
        mem_ready = 1'b1;
        comb("mem_done", 1'b0, 1'b0, 1'b0);
        exp_rn = 2'd0;
        clock_step("mem_done");
        mem_req = 1'b0; mem_ready = 1'b0;

        // Both operands forwarded in one edge: counter steps by one
        @(negedge clk);
        set_stage(1, 1'b1, 1'b0, 4'd5);
        set_stage(2, 1'b0, 1'b0, 4'd0);
        drive(1'b1, 1'b1, 4'd5, 4'd5, 1'b1);
        comb("fwd_both", 1'b0, 1'b0, 1'b0);
        exp_rn = 2'd2; exp_rm = 2'd2; exp_fwd = 4'd4;
        clock_step("fwd_both");

        // Branch beats load-use
        @(negedge clk);
        set_stage(0, 1'b1, 1'b1, 4'd5);
        branch_taken = 1'b1;
        comb("branch_lu", 1'b0, 1'b1, 1'b0);
        exp_rn = 2'd0; exp_rm = 2'd0;
        clock_step("branch_lu");

        @(negedge clk);
        set_stage(0, 1'b0, 1'b0, 4'd0);
        branch_taken = 1'b0;
        comb("fwd_again", 1'b0, 1'b0, 1'b0);
        exp_rn = 2'd2; exp_rm = 2'd2; exp_fwd = 4'd5;
        clock_step("fwd_again");

        // Freeze beats branch: registers hold
        @(negedge clk);
        branch_taken = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
        comb("branch_frz", 1'b0, 1'b1, 1'b1);
        clock_step("branch_frz");
        branch_taken = 1'b0; mem_req = 1'b0;

        // Stall counter saturation
        set_stage(1, 1'b1, 1'b0, 4'd7);
        drive(1'b0, 1'b1, 4'd7, 4'd0, 1'b0);
        exp_rn = 2'd0; exp_rm = 2'd0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            comb("sat", 1'b1, 1'b0, 1'b0);
            exp_stall = (exp_stall == 4'hF) ? 4'hF : exp_stall + 4'd1;
            clock_step($sformatf("sat%0d", i + 1));
        end

        @(negedge clk);
        cnt_clr = 1'b1;
        exp_stall = 4'd0; exp_fwd = 4'd0;
        clock_step("cnt_clr");

        @(negedge clk);
        cnt_clr = 1'b0;
        exp_stall = 4'd1;
        clock_step("post_clr");

        // Freeze, then async reset mid-wait
        @(negedge clk);
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i != 0) @(negedge clk);
            clock_step($sformatf("prewait%0d", i + 1));
        end
        #2;
        rst = 1'b0;
        exp_rn = '0; exp_rm = '0; exp_stall = '0; exp_fwd = '0; exp_tmo = 1'b0;
        comb("async_rst", 1'b1, 1'b0, 1'b1);
        push_exp("async_rst");
        check_regs();

        // Timeout counting restarts from zero after release
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (i != 0) @(negedge clk);
            exp_tmo = (i >= 14);
            clock_step($sformatf("rewait%0d", i + 1));
        end
        mem_req = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
